// File: rtl/regblock_arbiter.sv
// regblock_arbiter: round-robin arbiter/sequencer sharing one regblock port
// between NREQ requesters. One op in flight: IDLE (accept) -> ISSUE (regblock
// access) -> RESP (response handshake) -> IDLE.
// Optional feature: define REGBLOCK_ARB_STATS_EN to add per-requester 16-bit
// saturating grant counters on output stat_grants.
module regblock_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_idx,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic [AW-1:0]      rb_rd_index,
  output logic [AW-1:0]      rb_wr_index,
  output logic               rb_en,
  output logic [DW-1:0]      rb_d,
  input  logic [DW-1:0]      rb_q
`ifdef REGBLOCK_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;

  logic [PW-1:0]   win;
  logic            any_valid;
  logic            accept;

  // Rotating-priority pointer advance: one past the winner, wrapping at NREQ.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    if (w == PW'(NREQ - 1)) begin
      return '0;
    end
    return w + PW'(1);
  endfunction

  // Winner search: first valid requester at or after ptr, modulo NREQ.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned cand;
      cand = int'(ptr_q) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!any_valid && req_valid[PW'(cand)]) begin
        any_valid = 1'b1;
        win       = PW'(cand);
      end
    end
  end

  // Next-state and port decode; rst gates the handshake and write strobes.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    accept      = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    rb_en       = 1'b0;
    rb_rd_index = '0;
    rb_wr_index = '0;
    rb_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid && rst) begin
          req_ready[win] = 1'b1;
          accept         = 1'b1;
          ptr_d          = next_ptr(win);
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rb_rd_index = idx_q;
        rb_wr_index = idx_q;
        rb_d        = wdata_q;
        rb_en       = we_q & rst;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = rst;
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and arbitration pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Capture the winning op at acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= win;
      we_q    <= req_we[win];
      idx_q   <= req_idx[int'(win)*int'(AW) +: AW];
      wdata_q <= req_wdata[int'(win)*int'(DW) +: DW];
    end
  end

  // Read data is sampled during ISSUE and held through RESP; writes return 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      rdata_q <= we_q ? '0 : rb_q;
    end
  end

  assign rsp_rdata = rdata_q;

`ifdef REGBLOCK_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];

  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the stats port.
  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_grants[i*16 +: 16] = grant_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_regblock_arbiter.sv
// tb_regblock_arbiter: directed bench for regblock_arbiter (NREQ=2, DW=32, AW=1)
// with a behavioural two-entry regblock attached to the rb_* port.
module tb_regblock_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_idx;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      rb_rd_index;
  logic [AW-1:0]      rb_wr_index;
  logic               rb_en;
  logic [DW-1:0]      rb_d;
  logic [DW-1:0]      rb_q;
`ifdef REGBLOCK_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  regblock_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rb_rd_index(rb_rd_index), .rb_wr_index(rb_wr_index), .rb_en(rb_en),
    .rb_d(rb_d), .rb_q(rb_q)
`ifdef REGBLOCK_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  // Behavioural regblock: combinational read, write on posedge when en.
  logic [DW-1:0] mem [2] = '{default: '0};
  assign rb_q = mem[rb_rd_index];
  always @(posedge clk) begin
    if (rb_en) mem[rb_wr_index] <= rb_d;
  end

  // Count regblock write strobes.
  always @(posedge clk) begin
    if (rb_en) en_count = en_count + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int r);
    return NREQ'(1) << r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester obligation: an op that was not accepted must be held stable.
  logic [NREQ-1:0] pv = '0, pr = '0, pwe = '0;
  logic [NREQ*AW-1:0] pidx = '0;
  logic [NREQ*DW-1:0] pwd = '0;
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (pv[i] && !pr[i] && rst)
        check("req_hold", 64'({req_valid[i], req_we[i], req_idx[i*AW +: AW], req_wdata[i*DW +: DW]}),
              64'({1'b1, pwe[i], pidx[i*AW +: AW], pwd[i*DW +: DW]}));
    end
    pv = req_valid; pr = req_ready; pwe = req_we; pidx = req_idx; pwd = req_wdata;
  end

  task automatic set_op(input int r, input logic we, input logic [AW-1:0] idx, input logic [DW-1:0] wd);
    req_we[r]              = we;
    req_idx[r*AW +: AW]    = idx;
    req_wdata[r*DW +: DW]  = wd;
    req_valid[r]           = 1'b1;
  endtask

  // Wait (bounded) for a grant to appear; returns at a negedge.
  task automatic wait_grant(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (req_ready == '0) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  // Single op from requester r with rsp_ready held high; called just after a posedge.
  task automatic do_op(input string name, input int r, input logic we, input logic [AW-1:0] idx,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp);
    int en0;
    rsp_ready[r] = 1'b1;
    set_op(r, we, idx, wd);
    wait_grant(name);
    check({name, "_grant"}, 64'(req_ready), 64'(oh(r)));
    en0 = en_count;
    step();
    req_valid[r] = 1'b0;
    @(negedge clk);
    check({name, "_rb_en"}, 64'(rb_en), 64'(we));
    check({name, "_rb_idx"}, 64'({rb_rd_index, rb_wr_index}), 64'({idx, idx}));
    if (we) check({name, "_rb_d"}, 64'(rb_d), 64'(wd));
    step();
    @(negedge clk);
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(oh(r)));
    check({name, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp));
    step();
    check({name, "_en_pulses"}, 64'(en_count - en0), 64'(we));
  endtask

  typedef struct {
    int              r;
    logic            we;
    logic [AW-1:0]   idx;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   exp;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int ng, nr, owner, g, en0;
    int cnt [NREQ];
    int exp_seq [8];
    logic drop;

    vecs[0] = '{0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 1'b0, 32'hA5A50001, 32'h0};
    vecs[3] = '{1, 1'b0, 1'b0, 32'h0,        32'hA5A50001};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1, 1'b1, 1'b1, 32'h0000FFFF, 32'h0};
    vecs[6] = '{0, 1'b0, 1'b1, 32'h0,        32'h0000FFFF};
    exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0};

    rst = 1'b0; req_valid = '0; req_we = '0; req_idx = '0; req_wdata = '0; rsp_ready = '0;

    // Reset, then idle outputs for 10 cycles.
    step(); step();
    check("reset_outs", 64'({req_ready, rsp_valid, rb_en}), 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", 64'({req_ready, rsp_valid, rb_en}), 64'(0));
      check("idle_rb", 64'({rb_rd_index, rb_wr_index, rb_d}), 64'(0));
      step();
    end

    // Table of single ops.
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].exp);
    end

    // Both requesters hold valid for 4 reads each; ptr is 1 after vec6.
    rsp_ready = 2'b11;
    set_op(0, 1'b0, 1'b1, 32'h0);
    set_op(1, 1'b0, 1'b0, 32'h0);
    ng = 0; nr = 0; owner = 0; cnt[0] = 0; cnt[1] = 0;
    for (int c = 0; c < 100 && nr < 8; c++) begin
      @(negedge clk);
      drop = 1'b0; g = 0;
      if (req_ready != '0) begin
        g = (req_ready == 2'b10) ? 1 : 0;
        check("rr_grant", 64'(req_ready), 64'(oh(exp_seq[ng % 8])));
        ng++; cnt[g]++; owner = g;
        drop = (cnt[g] == 4);
      end
      if (rsp_valid != '0) begin
        check("rr_owner", 64'(rsp_valid), 64'(oh(owner)));
        check("rr_rdata", 64'(rsp_rdata), 64'(owner == 0 ? 32'h0000FFFF : 32'hA5A50001));
        nr++;
      end
      step();
      if (drop) req_valid[g] = 1'b0;
    end
    check("rr_done", 64'({ng[7:0], nr[7:0]}), 64'({8'd8, 8'd8}));

    // Response backpressure: held RESP while req1 waits.
    rsp_ready = 2'b10;
    set_op(0, 1'b0, 1'b1, 32'h0);
    wait_grant("bp");
    check("bp_grant", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    set_op(1, 1'b0, 1'b0, 32'h0);
    step();
    en0 = en_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({rsp_valid, req_ready, rsp_rdata}), 64'({2'b01, 2'b00, 32'h0000FFFF}));
      step();
    end
    check("bp_no_en", 64'(en_count - en0), 64'(0));
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_hs_cycle", 64'({rsp_valid, req_ready}), 64'({2'b01, 2'b00}));
    step();
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    step();
    @(negedge clk);
    check("bp_r1_rsp", 64'({rsp_valid, rsp_rdata}), 64'({2'b10, 32'hA5A50001}));
    step();

    // Reset during ISSUE of a write to idx 0; ptr must restart at 0.
    rsp_ready = 2'b11;
    set_op(0, 1'b1, 1'b0, 32'h12345678);
    wait_grant("rst");
    check("rst_grant", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    rst = 1'b0;
    en0 = en_count;
    @(negedge clk);
    check("rst_issue_en", 64'({rb_en, rsp_valid, req_ready}), 64'(0));
    step();
    rst = 1'b1;
    check("rst_no_write", 64'(en_count - en0), 64'(0));
    set_op(0, 1'b0, 1'b0, 32'h0);
    set_op(1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check("rst_ptr0", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    step();
    @(negedge clk);
    check("rst_readback", 64'({rsp_valid, rsp_rdata}), 64'({2'b01, 32'hA5A50001}));
    step();
    @(negedge clk);
    check("rst_r1_grant", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    step();
    @(negedge clk);
    check("rst_r1_rsp", 64'({rsp_valid, rsp_rdata}), 64'({2'b10, 32'h0000FFFF}));
    step();

`ifdef REGBLOCK_ARB_STATS_EN
    // Grant counters: cleared by reset, three grants to req1.
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("stats_reset", 64'(stat_grants), 64'(0));
    for (int i = 0; i < 3; i++) begin
      do_op("stats_op", 1, 1'b0, 1'b0, 32'h0, 32'hA5A50001);
    end
    check("stats_count", 64'(stat_grants), 64'({16'd3, 16'd0}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
